arts_err_stats: RTL and testbench



---
 rtl/arts_pkg.sv | 36 +++
 rtl/arts_exact_ed.sv | 84 ++++++++
 rtl/arts_err_stats.sv | 182 ++++++++++++++++++
 tb/tb_arts_err_stats.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arts_pkg.sv
// Shared definitions for the ARTS error-statistics collector.
package arts_pkg;

    localparam int unsigned NDefault  = 8;
    // Beat latency from acceptance to accumulator update (S1, S2, S3).
    localparam int unsigned PipeDepth = 3;
    // Working width of the saturating adder; counters and sums must fit within it.
    localparam int unsigned SatW      = 64;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } stats_state_e;

    // Saturating add of a w-bit quantity held in the low bits of a SatW-bit word.
    // Returns {saturated, result}; the result clamps at 2^w-1.
    function automatic logic [SatW:0] sat_add(
        input logic [SatW-1:0] a,
        input logic [SatW-1:0] b,
        input int unsigned     w
    );
        logic [SatW:0] one;
        logic [SatW:0] sum;
        logic [SatW:0] lim;
        one = {{SatW{1'b0}}, 1'b1};
        sum = {1'b0, a} + {1'b0, b};
        lim = (one << w) - one;
        if (sum > lim) begin
            return {1'b1, lim[SatW-1:0]};
        end
        return {1'b0, sum[SatW-1:0]};
    endfunction

endpackage

// File: rtl/arts_exact_ed.sv
// S1-S2 datapath: exact product, then absolute error distance against the approximate product.
module arts_exact_ed
    import arts_pkg::*;
#(
    parameter int unsigned N = NDefault
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_flush,
    input  logic           i_valid,
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    input  logic [2*N-1:0] i_appr,
    output logic           o_s1_valid,
    output logic           o_valid,
    output logic [N-1:0]   o_a,
    output logic [N-1:0]   o_b,
    output logic [2*N-1:0] o_ed
);

    localparam int unsigned Stages = PipeDepth - 1;

    logic [Stages-1:0] r_vld;
    logic [N-1:0]      r_s1_a;
    logic [N-1:0]      r_s1_b;
    logic [2*N-1:0]    r_s1_exact;
    logic [2*N-1:0]    r_s1_appr;
    logic [N-1:0]      r_s2_a;
    logic [N-1:0]      r_s2_b;
    logic [2*N-1:0]    r_s2_ed;
    logic [2*N-1:0]    w_exact;
    logic [2*N-1:0]    w_ed;

    assign w_exact = {{N{1'b0}}, i_a} * {{N{1'b0}}, i_b};
    // The approximation may land on either side of the exact product.
    assign w_ed    = (r_s1_exact >= r_s1_appr) ? (r_s1_exact - r_s1_appr)
                                               : (r_s1_appr - r_s1_exact);

    // Valid shadow bits travel with the data; a flush empties every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else if (i_flush) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[Stages-2:0], i_valid};
        end
    end

    // S1: capture the accepted beat together with its exact product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_exact <= '0;
            r_s1_appr  <= '0;
        end else if (i_valid) begin
            r_s1_a     <= i_a;
            r_s1_b     <= i_b;
            r_s1_exact <= w_exact;
            r_s1_appr  <= i_appr;
        end
    end

    // S2: capture the error distance and the operands that produced it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_a  <= '0;
            r_s2_b  <= '0;
            r_s2_ed <= '0;
        end else if (r_vld[0]) begin
            r_s2_a  <= r_s1_a;
            r_s2_b  <= r_s1_b;
            r_s2_ed <= w_ed;
        end
    end

    assign o_s1_valid = r_vld[0];
    assign o_valid    = r_vld[Stages-1];
    assign o_a        = r_s2_a;
    assign o_b        = r_s2_b;
    assign o_ed       = r_s2_ed;

endmodule

// File: rtl/arts_err_stats.sv
// Run-level error statistics for the ARTS approximate multiplier, with valid/ack readout.
module arts_err_stats
    import arts_pkg::*;
#(
    parameter int unsigned N     = NDefault,
    parameter int unsigned CNT_W = 17,
    parameter int unsigned SUM_W = 2 * N + CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [2*N-1:0]   in_appr,
    input  logic             in_last,
    output logic             stat_valid,
    input  logic             stat_ack,
    output logic [CNT_W-1:0] stat_count,
    output logic [CNT_W-1:0] stat_err_cnt,
    output logic [SUM_W-1:0] stat_sum_ed,
    output logic [2*N-1:0]   stat_max_ed,
    output logic [N-1:0]     stat_worst_a,
    output logic [N-1:0]     stat_worst_b,
    output logic             overflow
);

    stats_state_e     r_state;
    stats_state_e     w_state_d;
    logic             w_accept;
    logic             w_s1_valid;
    logic             w_s2_valid;
    logic [N-1:0]     w_s2_a;
    logic [N-1:0]     w_s2_b;
    logic [2*N-1:0]   w_ed;

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_err_cnt;
    logic [SUM_W-1:0] r_sum_ed;
    logic [2*N-1:0]   r_max_ed;
    logic [N-1:0]     r_worst_a;
    logic [N-1:0]     r_worst_b;
    logic             r_overflow;

    logic [CNT_W-1:0] w_count_d;
    logic [CNT_W-1:0] w_err_cnt_d;
    logic [SUM_W-1:0] w_sum_ed_d;
    logic [2*N-1:0]   w_max_ed_d;
    logic [N-1:0]     w_worst_a_d;
    logic [N-1:0]     w_worst_b_d;
    logic             w_overflow_d;

    logic [SatW:0]    w_cnt_res;
    logic [SatW:0]    w_err_res;
    logic [SatW:0]    w_sum_res;
    logic             w_unused_bits;

    assign in_ready = ((r_state == StIdle) || (r_state == StRun)) && !clr;
    assign w_accept = in_valid && in_ready;

    arts_exact_ed #(
        .N (N)
    ) u_exact_ed (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (clr),
        .i_valid    (w_accept),
        .i_a        (in_a),
        .i_b        (in_b),
        .i_appr     (in_appr),
        .o_s1_valid (w_s1_valid),
        .o_valid    (w_s2_valid),
        .o_a        (w_s2_a),
        .o_b        (w_s2_b),
        .o_ed       (w_ed)
    );

    assign w_cnt_res = sat_add(SatW'(r_count), SatW'(1), CNT_W);
    assign w_err_res = sat_add(SatW'(r_err_cnt), SatW'(w_ed != '0), CNT_W);
    assign w_sum_res = sat_add(SatW'(r_sum_ed), SatW'(w_ed), SUM_W);
    // Upper bits of the adder results are always zero after clamping.
    assign w_unused_bits = ^{w_cnt_res[SatW-1:CNT_W], w_err_res[SatW-1:CNT_W],
                             w_sum_res[SatW-1:SUM_W]};

    // Run FSM: accept beats until the last one, drain the pipeline, hold results until ack.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d = in_last ? StDrain : StRun;
                end
            end
            StRun: begin
                if (w_accept && in_last) begin
                    w_state_d = StDrain;
                end
            end
            StDrain: begin
                // S1 empty means any S2 beat is absorbed on this edge.
                if (!w_s1_valid) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                if (stat_ack) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
        if (clr) begin
            w_state_d = StIdle;
        end
    end

    // Accumulator next state: absorb the S2 beat, cleared by clr or by ack in DONE.
    always_comb begin
        w_count_d    = r_count;
        w_err_cnt_d  = r_err_cnt;
        w_sum_ed_d   = r_sum_ed;
        w_max_ed_d   = r_max_ed;
        w_worst_a_d  = r_worst_a;
        w_worst_b_d  = r_worst_b;
        w_overflow_d = r_overflow;
        if (w_s2_valid) begin
            w_count_d    = w_cnt_res[CNT_W-1:0];
            w_err_cnt_d  = w_err_res[CNT_W-1:0];
            w_sum_ed_d   = w_sum_res[SUM_W-1:0];
            w_overflow_d = r_overflow | w_cnt_res[SatW] | w_err_res[SatW] | w_sum_res[SatW];
            // Strictly greater: ties keep the earlier beat.
            if (w_ed > r_max_ed) begin
                w_max_ed_d  = w_ed;
                w_worst_a_d = w_s2_a;
                w_worst_b_d = w_s2_b;
            end
        end
        if (clr || ((r_state == StDone) && stat_ack)) begin
            w_count_d    = '0;
            w_err_cnt_d  = '0;
            w_sum_ed_d   = '0;
            w_max_ed_d   = '0;
            w_worst_a_d  = '0;
            w_worst_b_d  = '0;
            w_overflow_d = 1'b0;
        end
    end

    // State and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_count    <= '0;
            r_err_cnt  <= '0;
            r_sum_ed   <= '0;
            r_max_ed   <= '0;
            r_worst_a  <= '0;
            r_worst_b  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_count    <= w_count_d;
            r_err_cnt  <= w_err_cnt_d;
            r_sum_ed   <= w_sum_ed_d;
            r_max_ed   <= w_max_ed_d;
            r_worst_a  <= w_worst_a_d;
            r_worst_b  <= w_worst_b_d;
            r_overflow <= w_overflow_d;
        end
    end

    assign stat_valid   = (r_state == StDone);
    assign stat_count   = r_count;
    assign stat_err_cnt = r_err_cnt;
    assign stat_sum_ed  = r_sum_ed;
    assign stat_max_ed  = r_max_ed;
    assign stat_worst_a = r_worst_a;
    assign stat_worst_b = r_worst_b;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_arts_err_stats.sv
// Bench for arts_err_stats: a default instance and a CNT_W=2 instance share one stimulus.
module tb_arts_err_stats;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        stat_ack = 1'b0;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [15:0] in_appr = '0;

    logic        m_ready, m_valid, m_ovf;
    logic [16:0] m_count, m_err;
    logic [32:0] m_sum;
    logic [15:0] m_max;
    logic [7:0]  m_wa, m_wb;

    logic        s_ready, s_valid, s_ovf;
    logic [1:0]  s_count, s_err;
    logic [17:0] s_sum;
    logic [15:0] s_max;
    logic [7:0]  s_wa, s_wb;

    int total = 0;
    int bad = 0;

    // Model: beats of the current run with the cycle each was accepted in.
    int q_a[$];
    int q_b[$];
    int q_appr[$];
    int q_t[$];
    bit closed = 1'b0;
    bit started = 1'b0;
    int last_t = 0;
    int cyc = 0;

    arts_err_stats u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .in_valid     (in_valid),
        .in_ready     (m_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_appr      (in_appr),
        .in_last      (in_last),
        .stat_valid   (m_valid),
        .stat_ack     (stat_ack),
        .stat_count   (m_count),
        .stat_err_cnt (m_err),
        .stat_sum_ed  (m_sum),
        .stat_max_ed  (m_max),
        .stat_worst_a (m_wa),
        .stat_worst_b (m_wb),
        .overflow     (m_ovf)
    );

    arts_err_stats #(
        .CNT_W (2)
    ) u_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .in_valid     (in_valid),
        .in_ready     (s_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_appr      (in_appr),
        .in_last      (in_last),
        .stat_valid   (s_valid),
        .stat_ack     (stat_ack),
        .stat_count   (s_count),
        .stat_err_cnt (s_err),
        .stat_sum_ed  (s_sum),
        .stat_max_ed  (s_max),
        .stat_worst_a (s_wa),
        .stat_worst_b (s_wb),
        .overflow     (s_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void clear_model();
        q_a.delete();
        q_b.delete();
        q_appr.delete();
        q_t.delete();
        closed = 1'b0;
    endfunction

    // Statistics over every beat that has had time to reach the accumulators.
    task automatic model_stats(input int cw, output longint cnt, output longint err,
                               output longint sum, output longint mx, output longint wa,
                               output longint wb, output bit ovf);
        longint n, e, s, ed, lc, ls;
        n = 0; e = 0; s = 0; mx = 0; wa = 0; wb = 0;
        lc = (longint'(1) << cw) - 1;
        ls = (longint'(1) << (16 + cw)) - 1;
        foreach (q_t[i]) begin
            if (q_t[i] + 3 <= cyc) begin
                ed = longint'(q_a[i] * q_b[i]) - longint'(q_appr[i]);
                if (ed < 0) ed = -ed;
                n++;
                if (ed != 0) e++;
                s += ed;
                if (ed > mx) begin
                    mx = ed;
                    wa = q_a[i];
                    wb = q_b[i];
                end
            end
        end
        ovf = (n > lc) || (e > lc) || (s > ls);
        cnt = (n > lc) ? lc : n;
        err = (e > lc) ? lc : e;
        sum = (s > ls) ? ls : s;
    endtask

    // Model update on each active edge, from the inputs the DUT sees on that edge.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                clear_model();
            end else begin
                bit v, rdy;
                v = closed && (cyc >= last_t + 3);
                rdy = !closed && !clr;
                if (clr) begin
                    clear_model();
                end else if (stat_ack && v) begin
                    clear_model();
                end else if (in_valid && rdy) begin
                    q_a.push_back(int'(in_a));
                    q_b.push_back(int'(in_b));
                    q_appr.push_back(int'(in_appr));
                    q_t.push_back(cyc);
                    if (in_last) begin
                        closed = 1'b1;
                        last_t = cyc;
                    end
                end
            end
            cyc++;
        end
    end

    // Compare both instances against the model every cycle out of reset.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && started) begin
                longint cnt, err, sum, mx, wa, wb;
                bit ovf, exp_rdy, exp_v;
                exp_rdy = !closed && !clr;
                exp_v = closed && (cyc >= last_t + 3);
                check("m_in_ready", m_ready, exp_rdy);
                check("m_stat_valid", m_valid, exp_v);
                check("s_in_ready", s_ready, exp_rdy);
                check("s_stat_valid", s_valid, exp_v);
                model_stats(17, cnt, err, sum, mx, wa, wb, ovf);
                check("m_count", m_count, cnt);
                check("m_err_cnt", m_err, err);
                check("m_sum_ed", m_sum, sum);
                check("m_max_ed", m_max, mx);
                check("m_worst_a", m_wa, wa);
                check("m_worst_b", m_wb, wb);
                check("m_overflow", m_ovf, ovf);
                model_stats(2, cnt, err, sum, mx, wa, wb, ovf);
                check("s_count", s_count, cnt);
                check("s_err_cnt", s_err, err);
                check("s_sum_ed", s_sum, sum);
                check("s_max_ed", s_max, mx);
                check("s_worst_a", s_wa, wa);
                check("s_worst_b", s_wb, wb);
                check("s_overflow", s_ovf, ovf);
            end
        end
    end

    task automatic drive(input int a, input int b, input int appr, input bit last);
        in_a = 8'(a);
        in_b = 8'(b);
        in_appr = 16'(appr);
        in_last = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bounded wait for stat_valid; an expired bound shows up as a failed comparison.
    task automatic wait_valid(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid) break;
        end
        check(name, m_valid, 1);
    endtask

    task automatic do_ack();
        @(posedge clk);
        #1;
        stat_ack = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        stat_ack = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        started = 1'b1;
        @(negedge clk);
        check("reset in_ready", m_ready, 1);
        check("reset stat_valid", m_valid, 0);
        check("reset count", m_count, 0);

        // Reset in the middle of a run discards it.
        drive(5, 5, 20, 0);
        drive(6, 6, 40, 0);
        drive(7, 7, 49, 0);
        drive(8, 8, 60, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrun reset count", m_count, 0);
        check("midrun reset sum", m_sum, 0);
        check("midrun reset in_ready", m_ready, 1);
        check("midrun reset stat_valid", m_valid, 0);

        // Single beat: stat_valid exactly three cycles after acceptance.
        drive(255, 255, 65000, 1);
        @(negedge clk);
        check("single t+1 stat_valid", m_valid, 0);
        @(negedge clk);
        check("single t+2 stat_valid", m_valid, 0);
        @(negedge clk);
        check("single t+3 stat_valid", m_valid, 1);
        check("single count", m_count, 1);
        check("single err_cnt", m_err, 1);
        check("single sum", m_sum, 25);
        check("single max", m_max, 25);
        check("single worst_a", m_wa, 255);
        check("single worst_b", m_wb, 255);
        do_ack();
        @(negedge clk);
        check("after ack count", m_count, 0);
        check("after ack stat_valid", m_valid, 0);

        // Error on both sides of the exact product, plus an exact beat.
        drive(10, 10, 103, 0);
        drive(3, 3, 9, 1);
        wait_valid("mixed stat_valid");
        check("mixed count", m_count, 2);
        check("mixed err_cnt", m_err, 1);
        check("mixed sum", m_sum, 3);
        check("mixed max", m_max, 3);
        check("mixed worst_a", m_wa, 10);
        check("mixed worst_b", m_wb, 10);
        do_ack();

        // Equal maxima keep the first beat; in_valid held through drain and done.
        drive(4, 4, 14, 0);
        drive(2, 8, 18, 0);
        drive(1, 1, 1, 1);
        in_a = 8'd9;
        in_b = 8'd9;
        in_appr = 16'd0;
        in_valid = 1'b1;
        wait_valid("ties stat_valid");
        check("ties max", m_max, 2);
        check("ties worst_a", m_wa, 4);
        check("ties worst_b", m_wb, 4);
        check("ties count", m_count, 3);
        check("ties in_ready", m_ready, 0);
        idle(3);
        @(negedge clk);
        check("ties held count", m_count, 3);
        do_ack();
        @(negedge clk);
        check("ties ack count", m_count, 0);
        check("ties ack max", m_max, 0);
        check("ties ack worst_a", m_wa, 0);

        // Saturation in the narrow instance.
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 2, i == 5);
        end
        wait_valid("sat stat_valid");
        check("sat count", s_count, 3);
        check("sat err_cnt", s_err, 3);
        check("sat overflow", s_ovf, 1);
        check("sat sum", s_sum, 6);
        check("wide count", m_count, 6);
        check("wide overflow", m_ovf, 0);
        do_ack();
        @(negedge clk);
        check("sat ack overflow", s_ovf, 0);

        // clr during a run with a beat offered on the same cycle.
        drive(20, 20, 400, 0);
        drive(21, 21, 400, 0);
        in_a = 8'd22;
        in_b = 8'd22;
        in_appr = 16'd0;
        in_valid = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        check("clr in_ready", m_ready, 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        idle(4);
        @(negedge clk);
        check("clr count", m_count, 0);
        check("clr sum", m_sum, 0);
        check("clr stat_valid", m_valid, 0);
        check("clr in_ready idle", m_ready, 1);

        drive(2, 3, 7, 1);
        wait_valid("post clr stat_valid");
        check("post clr count", m_count, 1);
        check("post clr sum", m_sum, 1);
        do_ack();
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
